// File: rtl/serial_add_ctrl.sv
`timescale 1ns/1ps
// serial_add_ctrl
// Bit-serial add/subtract sequencer. One full-adder evaluation per clock,
// LSB first, with a registered carry. The parallel result, carry-out and
// signed overflow are presented together with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  launch request, accepted only while busy=0
//   sub    0: a+b+cin, 1: a-b (cin ignored); sampled with start
//   a, b   WIDTH-bit operands; sampled with start
//   cin    carry-in for add mode; sampled with start
//   busy   high for exactly WIDTH cycles while bits are processed
//   done   one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum    WIDTH-bit result, held until the next completion
//   cout   carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_c;

    always_comb begin
        // The single shared full-adder cell.
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and force carry-in.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {fa_s, res_q[WIDTH-1:1]};
                c_d    = fa_c;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Results are registered on entry to DONE so they are
                    // valid in the same cycle as the done pulse. c_q here is
                    // the carry into the MSB.
                    sum_d   = res_d;
                    cout_d  = fa_c;
                    ovf_d   = c_q ^ fa_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge. Launches one operation, checks busy for
    // exactly WIDTH cycles, then checks the done cycle. Returns in the done
    // cycle so a caller may restart back-to-back. With garble=1, start is
    // re-asserted with junk operands throughout the busy window.
    task automatic run_op(input string name, input vec_t v, input bit garble);
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        sub   = v.sub;
        @(posedge clk); #1;
        for (int i = 0; i < WIDTH; i++) begin
            start = garble;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            chk({name, "_busy"}, {30'd0, busy, done}, 32'b10);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({name, "_done"}, {30'd0, busy, done}, 32'b01);
        chk({name, "_sum"},  32'(sum), 32'(v.exp_sum));
        chk({name, "_cout"}, 32'(cout), 32'(v.exp_cout));
        chk({name, "_ovf"},  32'(ovf), 32'(v.exp_ovf));
    endtask

    task automatic idle_check(input string name, input int n, input logic [WIDTH-1:0] held);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk({name, "_idle"}, {30'd0, busy, done}, 32'b00);
            chk({name, "_held"}, 32'(sum), 32'(held));
        end
    endtask

    initial begin
        vec_t v;
        //             a      b      cin   sub   sum    cout  ovf
        vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[8] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst   = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #3 rst = 1'b1;
        #1;
        chk("rst_ctrl", {30'd0, busy, done}, 32'b00);
        chk("rst_res", {22'd0, sum, cout, ovf}, 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        idle_check("post_rst", 20, 8'h00);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 1'b0);
            idle_check($sformatf("vec%0d", i), 2, vecs[i].exp_sum);
        end

        // Start re-asserted during busy with new operands is ignored; then
        // start held in the done cycle restarts immediately.
        run_op("hs_first", vecs[0], 1'b1);
        v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        run_op("hs_b2b", v, 1'b0);
        idle_check("hs_b2b", 2, 8'h30);

        // Reset during RUN: no done pulse, results cleared.
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h05;
        cin   = 1'b0;
        sub   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {30'd0, busy, done}, 32'b00);
        chk("mid_rst_res", {22'd0, sum, cout, ovf}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        idle_check("mid_rst", 12, 8'h00);
        run_op("after_rst", vecs[0], 1'b0);
        idle_check("after_rst", 2, 8'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
